key_onehot_debounce: RTL and testbench

Front-end stage that feeds the 8-3 encoder on the switch/button board. It synchronises eight raw, bouncy, active-high key inputs and debounces them as a vector. It then accepts a press only when exactly one key is down, and presents a held, always-legal one-hot word on `oData` for the encoder's `iData`. Multi-key presses are flagged on `oError` and never reach the encoder.

---
 rtl/key_onehot_debounce.sv | 128 ++++++++++++
 tb/tb_key_onehot_debounce.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_onehot_debounce.sv
// Key front-end for the 8-3 encoder: synchronises and debounces eight raw keys,
// then accepts single-key presses only and holds a one-hot code.
module key_onehot_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [7:0] iKey,
    output logic [7:0] oData,
    output logic       oValid,
    output logic       oError
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    logic [7:0]    s1_q;
    logic [7:0]    s2_q;
    logic [7:0]    cand_q;
    logic [7:0]    cand_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [7:0]    stab_q;
    logic [7:0]    stab_d;
    state_t        state_q;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          error_q;
    logic          stab_onehot_s;

    function automatic logic is_onehot(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return (n == 4'd1);
    endfunction

    // Two-stage synchroniser for the asynchronous key levels.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            s1_q <= 8'h00;
            s2_q <= 8'h00;
        end else begin
            s1_q <= iKey;
            s2_q <= s1_q;
        end
    end

    // Vector debounce: any change of s2 restarts the window; the counter saturates.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        stab_d = stab_q;
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = {CW{1'b0}};
        end else if (cnt_q == CNT_MAX) begin
            stab_d = cand_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Debounce state registers.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            cand_q <= 8'h00;
            cnt_q  <= {CW{1'b0}};
            stab_q <= 8'h00;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            stab_q <= stab_d;
        end
    end

    assign stab_onehot_s = is_onehot(stab_q);

    // Press FSM; only an all-zero stable vector re-arms it, so oData stays one-hot.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= IDLE;
            data_q  <= 8'h01;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (stab_q == 8'h00) begin
                        state_q <= IDLE;
                    end else if (stab_onehot_s) begin
                        data_q  <= stab_q;
                        valid_q <= 1'b1;
                        state_q <= HELD;
                    end else begin
                        error_q <= 1'b1;
                        state_q <= HELD;
                    end
                end
                HELD: begin
                    if (stab_q == 8'h00) begin
                        error_q <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        state_q <= HELD;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    error_q <= 1'b0;
                end
            endcase
        end
    end

    assign oData  = data_q;
    assign oValid = valid_q;
    assign oError = error_q;

endmodule

// File: tb/tb_key_onehot_debounce.sv
// Self-checking bench for key_onehot_debounce: directed scenarios plus random
// key traffic compared against a window-based behavioural model.
module tb_key_onehot_debounce;

    localparam int D = 4;

    logic       iClk = 1'b0;
    logic       iRst = 1'b1;
    logic [7:0] iKey = 8'h00;
    logic [7:0] oData;
    logic       oValid;
    logic       oError;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: synchroniser pipeline, a history of the last D+1 synchronised values,
    // and the accept/hold rules applied to the stable vector.
    logic [7:0] m_s1;
    logic [7:0] m_stab;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_err;
    bit         m_held;
    logic [7:0] m_hist[$];

    key_onehot_debounce #(.DEBOUNCE_CYCLES(D)) dut (
        .iClk  (iClk),
        .iRst  (iRst),
        .iKey  (iKey),
        .oData (oData),
        .oValid(oValid),
        .oError(oError)
    );

    always #5 iClk = ~iClk;

    function automatic int enc(input logic [7:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 8; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic model_reset();
        m_s1    = 8'h00;
        m_stab  = 8'h00;
        m_data  = 8'h01;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_held  = 1'b0;
        m_hist.delete();
        for (int i = 0; i < D + 1; i++) m_hist.push_back(8'h00);
    endtask

    // Advance one rising edge, update the model, and return at edge+1.
    task automatic tick();
        logic [7:0] k;
        logic [7:0] new_stab;
        bit         same;
        k = iKey;
        @(posedge iClk);
        if (iRst) begin
            model_reset();
        end else begin
            same = 1'b1;
            foreach (m_hist[i]) if (m_hist[i] !== m_hist[0]) same = 1'b0;
            new_stab = same ? m_hist[0] : m_stab;
            m_valid = 1'b0;
            if (!m_held) begin
                if (m_stab != 8'h00) begin
                    if ($countones(m_stab) == 1) begin
                        m_data  = m_stab;
                        m_valid = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                    m_held = 1'b1;
                end
            end else if (m_stab == 8'h00) begin
                m_err  = 1'b0;
                m_held = 1'b0;
            end
            m_hist.push_back(m_s1);
            void'(m_hist.pop_front());
            m_s1   = k;
            m_stab = new_stab;
        end
        #1;
    endtask

    task automatic release_settle();
        iKey = 8'h00;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        int first;
        int cnt;
        iRst = 1'b1;
        iKey = 8'h00;
        repeat (2) tick();
        n_cmp++; if (oData !== 8'h01) begin n_fail++; $display("FAIL reset_data: got %h expected 01", oData); end
        n_cmp++; if (oValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", oValid); end
        n_cmp++; if (oError !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", oError); end
        iRst = 1'b0;
        iKey = 8'h10;
        repeat (12) tick();
        n_cmp++; if (oData !== 8'h10) begin n_fail++; $display("FAIL pre_reset_data: got %h expected 10", oData); end
        #2 iRst = 1'b1;
        #1;
        n_cmp++; if (oData !== 8'h01) begin n_fail++; $display("FAIL async_reset_data: got %h expected 01", oData); end
        n_cmp++; if (oValid !== 1'b0 || oError !== 1'b0) begin n_fail++; $display("FAIL async_reset_flags: got v=%b e=%b expected 0 0", oValid, oError); end
        model_reset();
        repeat (2) tick();
        iRst = 1'b0;
        first = 0;
        cnt = 0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (oValid) begin
                cnt++;
                if (first == 0) first = e;
            end
        end
        n_cmp++; if (first != D + 4 || cnt != 1) begin n_fail++; $display("FAIL reset_repress: valid edge %0d count %0d expected edge %0d count 1", first, cnt, D + 4); end
        n_cmp++; if (oData !== 8'h10) begin n_fail++; $display("FAIL reset_repress_data: got %h expected 10", oData); end
    endtask

    task automatic test_clean_press();
        int first;
        int cnt;
        logic [7:0] d_at_valid;
        release_settle();
        iKey = 8'h08;
        first = 0;
        cnt = 0;
        d_at_valid = 8'h00;
        for (int e = 1; e <= 14; e++) begin
            tick();
            if (oValid) begin
                cnt++;
                if (first == 0) begin
                    first = e;
                    d_at_valid = oData;
                end
            end
        end
        n_cmp++; if (first != D + 4 || cnt != 1) begin n_fail++; $display("FAIL clean_press_timing: valid edge %0d count %0d expected edge %0d count 1", first, cnt, D + 4); end
        n_cmp++; if (d_at_valid !== 8'h08) begin n_fail++; $display("FAIL clean_press_data: got %h expected 08", d_at_valid); end
        n_cmp++; if (enc(oData) != 3) begin n_fail++; $display("FAIL clean_press_encode: got %0d expected 3", enc(oData)); end
    endtask

    task automatic test_bounce();
        int first;
        int cnt;
        release_settle();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            iKey = ((i / 2) % 2 == 0) ? 8'h20 : 8'h00;
            tick();
            if (oValid) cnt++;
        end
        n_cmp++; if (cnt != 0) begin n_fail++; $display("FAIL bounce_quiet: got %0d pulses expected 0", cnt); end
        iKey = 8'h20;
        first = 0;
        cnt = 0;
        for (int e = 1; e <= 14; e++) begin
            tick();
            if (oValid) begin
                cnt++;
                if (first == 0) first = e;
            end
        end
        n_cmp++; if (first != D + 4 || cnt != 1) begin n_fail++; $display("FAIL bounce_accept: valid edge %0d count %0d expected edge %0d count 1", first, cnt, D + 4); end
        n_cmp++; if (oData !== 8'h20) begin n_fail++; $display("FAIL bounce_data: got %h expected 20", oData); end
    endtask

    task automatic test_multi_key();
        int first;
        int cnt;
        release_settle();
        iKey = 8'h41;
        first = 0;
        cnt = 0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (oValid) cnt++;
            if (oError && first == 0) first = e;
        end
        n_cmp++; if (first != D + 4) begin n_fail++; $display("FAIL multi_error_edge: got %0d expected %0d", first, D + 4); end
        n_cmp++; if (cnt != 0) begin n_fail++; $display("FAIL multi_no_valid: got %0d pulses expected 0", cnt); end
        n_cmp++; if (oData !== 8'h20) begin n_fail++; $display("FAIL multi_data_kept: got %h expected 20", oData); end
        iKey = 8'h00;
        first = 0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (!oError && first == 0) first = e;
        end
        n_cmp++; if (first != D + 4) begin n_fail++; $display("FAIL multi_release_edge: got %0d expected %0d", first, D + 4); end
    endtask

    task automatic test_hold_change();
        int cnt;
        int first;
        release_settle();
        iKey = 8'h02;
        cnt = 0;
        repeat (12) begin
            tick();
            if (oValid) cnt++;
        end
        n_cmp++; if (cnt != 1 || oData !== 8'h02) begin n_fail++; $display("FAIL hold_first_press: got %0d pulses data %h expected 1 pulse data 02", cnt, oData); end
        cnt = 0;
        iKey = 8'h82;
        repeat (10) begin
            tick();
            if (oValid) cnt++;
        end
        iKey = 8'h80;
        repeat (10) begin
            tick();
            if (oValid) cnt++;
        end
        n_cmp++; if (cnt != 0 || oData !== 8'h02 || oError !== 1'b0) begin n_fail++; $display("FAIL hold_ignore: got %0d pulses data %h err %b expected 0 02 0", cnt, oData, oError); end
        release_settle();
        iKey = 8'h80;
        first = 0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (oValid && first == 0) first = e;
        end
        n_cmp++; if (first != D + 4 || oData !== 8'h80) begin n_fail++; $display("FAIL hold_repress: edge %0d data %h expected edge %0d data 80", first, oData, D + 4); end
    endtask

    task automatic test_glitch();
        bit moved;
        iKey = 8'h00;
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        repeat (3) tick();
        iKey = 8'h04;
        tick();
        iKey = 8'h00;
        moved = 1'b0;
        repeat (15) begin
            tick();
            if (oValid !== 1'b0 || oData !== 8'h01 || oError !== 1'b0) moved = 1'b1;
        end
        n_cmp++; if (moved) begin n_fail++; $display("FAIL glitch_quiet: outputs left reset values, now data %h v %b e %b", oData, oValid, oError); end
    endtask

    task automatic test_random();
        int kind;
        int hold;
        int a;
        int b;
        for (int seg = 0; seg < 200; seg++) begin
            kind = $urandom_range(0, 3);
            a = $urandom_range(0, 7);
            b = $urandom_range(0, 7);
            case (kind)
                0:       iKey = 8'h00;
                1:       iKey = 8'h01 << a;
                2:       iKey = (8'h01 << a) | (8'h01 << b);
                default: iKey = 8'($urandom);
            endcase
            if ($urandom_range(0, 39) == 0) iRst = 1'b1;
            hold = $urandom_range(1, 14);
            for (int c = 0; c < hold; c++) begin
                tick();
                iRst = 1'b0;
                n_cmp++; if (oData !== m_data) begin n_fail++; $display("FAIL rand_data: seg %0d got %h expected %h", seg, oData, m_data); end
                n_cmp++; if (oValid !== m_valid) begin n_fail++; $display("FAIL rand_valid: seg %0d got %b expected %b", seg, oValid, m_valid); end
                n_cmp++; if (oError !== m_err) begin n_fail++; $display("FAIL rand_error: seg %0d got %b expected %b", seg, oError, m_err); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_multi_key();
        test_hold_change();
        test_glitch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
